// File: rtl/iaf.sv
// iaf -- integrate-and-fire neuron.
//
// Each cycle the weighted sum of the spiking synaptic inputs is added to an
// unsigned membrane potential. The sum saturates at the top of the register,
// then a constant leak is removed with a floor at zero. If the result reaches
// THRESHOLD, a one-cycle spike is registered and the potential returns to 0.
// latinhib clears the potential and suppresses firing. Refractory behaviour
// comes from the external bus ORing spike back into latinhib.
//
// Ports
//   weights_lo [INPUTS]  LSB of each input's 2-bit weight
//   weights_hi [INPUTS]  MSB of each input's 2-bit weight
//   signals    [INPUTS]  per-input spike this cycle
//   clk                  rising-edge clock
//   rstb                 asynchronous reset, active high
//   latinhib             lateral inhibition: clears the potential, blocks firing
//   spike                registered one-cycle firing pulse

// Per-synapse contribution: the 2-bit weight when the input spikes, else 0.
module iaf_syn (
  input  logic       w_lo,
  input  logic       w_hi,
  input  logic       sig,
  output logic [1:0] contrib
);
  assign contrib = sig ? {w_hi, w_lo} : 2'd0;
endmodule

module iaf #(
  parameter int INPUTS    = 25,
  parameter int THRESHOLD = 64,
  parameter int LEAK      = 1,
  parameter int POT_WIDTH = 10
) (
  input  logic [INPUTS-1:0] weights_lo,
  input  logic [INPUTS-1:0] weights_hi,
  input  logic [INPUTS-1:0] signals,
  input  logic              clk,
  input  logic              rstb,
  input  logic              latinhib,
  output logic              spike
);
  // The sum must hold 3*INPUTS without overflow.
  localparam int SUM_W = $clog2(3*INPUTS + 1);
  // The accumulator has one bit above the wider operand, so potential + sum
  // can never wrap before saturation is applied.
  localparam int EW    = ((POT_WIDTH > SUM_W) ? POT_WIDTH : SUM_W) + 1;

  localparam logic [EW-1:0]        POT_MAX = {{(EW-POT_WIDTH){1'b0}}, {POT_WIDTH{1'b1}}};
  localparam logic [POT_WIDTH-1:0] LEAK_P  = POT_WIDTH'(LEAK);

  logic [INPUTS-1:0][1:0] contrib;
  logic [SUM_W-1:0]       sum;
  logic [POT_WIDTH-1:0]   potential;
  logic [EW-1:0]          acc;
  logic [POT_WIDTH-1:0]   sat;
  logic [POT_WIDTH-1:0]   next_pot;
  logic                   fire;

  // One synapse instance per input.
  for (genvar i = 0; i < INPUTS; i++) begin : g_syn
    iaf_syn u_syn (
      .w_lo    (weights_lo[i]),
      .w_hi    (weights_hi[i]),
      .sig     (signals[i]),
      .contrib (contrib[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < INPUTS; i++)
      sum = sum + SUM_W'(contrib[i]);
  end

  // Saturate first, then leak, so a large sum against a near-full potential
  // settles just below the ceiling rather than wrapping.
  always_comb begin
    acc      = EW'(potential) + EW'(sum);
    sat      = (acc > POT_MAX) ? {POT_WIDTH{1'b1}} : acc[POT_WIDTH-1:0];
    next_pot = (sat >= LEAK_P) ? sat - LEAK_P : '0;
    fire     = 32'(next_pot) >= 32'(THRESHOLD);
  end

  // Inhibition takes priority over firing.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      potential <= '0;
      spike     <= 1'b0;
    end else if (latinhib) begin
      potential <= '0;
      spike     <= 1'b0;
    end else if (fire) begin
      potential <= '0;
      spike     <= 1'b1;
    end else begin
      potential <= next_pot;
      spike     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_iaf.sv
module tb_iaf;
  localparam int N = 25;

  logic [N-1:0] weights_lo, weights_hi, signals;
  logic         clk, rstb, lat_drv, tie;
  logic         latinhib;
  logic         spike;

  int nvec, nerr;

  // Bus behaviour: the spike can be ORed back into latinhib.
  assign latinhib = lat_drv | (tie & spike);

  iaf dut (
    .weights_lo (weights_lo),
    .weights_hi (weights_hi),
    .signals    (signals),
    .clk        (clk),
    .rstb       (rstb),
    .latinhib   (latinhib),
    .spike      (spike)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; sample at the following falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input int sp, input int pot);
    chk({tag, ".spike"}, int'(spike), sp);
    chk({tag, ".pot"}, int'(dut.potential), pot);
  endtask

  // Asynchronous reset pulse taken between edges.
  task automatic pulse_rst;
    #1 rstb = 1'b1;
    #1 rstb = 1'b0;
  endtask

  initial begin
    nvec = 0; nerr = 0;
    weights_lo = '0; weights_hi = '0; signals = '0;
    lat_drv = 1'b0; tie = 1'b0; rstb = 1'b1;

    // Reset state held through clock edges.
    tick();
    chk_state("reset", 0, 0);
    rstb = 1'b0;

    // Full weights and inputs, spike tied back: 1,0,1,0.
    weights_lo = '1; weights_hi = '1; signals = '1; tie = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_state($sformatf("full_tie%0d", k), (k % 2 == 0) ? 1 : 0, 0);
    end
    tie = 1'b0;
    pulse_rst();

    // Weight 1, ten inputs active: 9,18,...,63 then fire at 72.
    weights_lo = '1; weights_hi = '0; signals = 25'h3FF;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_state($sformatf("ramp%0d", k), 0, 9*k);
    end
    tick();
    chk_state("ramp_fire", 1, 0);
    pulse_rst();

    // latinhib held high: nothing ever accumulates.
    weights_lo = '1; weights_hi = '1; signals = '1; lat_drv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_state($sformatf("inhib%0d", k), 0, 0);
    end
    lat_drv = 1'b0;

    // Build to 5, then leak down with a floor at zero.
    weights_lo = 25'h3; weights_hi = 25'h3; signals = 25'h3;
    tick();
    chk_state("build5", 0, 5);
    signals = '0;
    for (int k = 4; k >= -2; k--) begin
      tick();
      chk_state($sformatf("leak%0d", k), 0, (k > 0) ? k : 0);
    end

    // Zero weights contribute nothing even with every input spiking.
    weights_lo = '0; weights_hi = '0; signals = '1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_state($sformatf("zero_w%0d", k), 0, 0);
    end

    // Inputs changing between edges are ignored: glitch full inputs, restore.
    weights_lo = '1; weights_hi = '1;
    #2 weights_lo = '0; weights_hi = '0;
    tick();
    chk_state("between_edges", 0, 0);

    // Sum 61 -> potential 60.
    weights_lo = 25'h1FFFFF; weights_hi = 25'h0FFFFF; signals = '1;
    tick();
    chk_state("to60", 0, 60);

    // Inhibition coinciding with a threshold crossing wins.
    weights_lo = '1; weights_hi = '1; lat_drv = 1'b1;
    tick();
    chk_state("inhib_wins", 0, 0);
    lat_drv = 1'b0;

    // Back to 60, then reset mid-cycle clears immediately.
    weights_lo = 25'h1FFFFF; weights_hi = 25'h0FFFFF;
    tick();
    chk_state("again60", 0, 60);
    #1 rstb = 1'b1;
    #1;
    chk_state("rst_async", 0, 0);
    rstb = 1'b0;
    weights_lo = '1; weights_hi = '1;
    tick();
    chk_state("post_rst_fire", 1, 0);

    // Reset while spike is high drops it without an edge.
    #1 rstb = 1'b1;
    #1;
    chk("rst_spike", int'(spike), 0);
    rstb = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Watchdog: the bench must always end by itself.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
